alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one combinational 4-bit opcode ALU between two requesters.
- Arbitrates round-robin, latches the winner's command and drives the ALU ports from registers.
- Captures the ALU result, masked to the bits that opcode defines, and returns it with the requester ID over a valid/ready result port.
- Sits between two command sources (e.g. a sequencer and a test/debug port) and the ALU instance.

Parameters:
- DATA_W, 4: operand width; must match the ALU (result width is 2*DATA_W).
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_opcode  input  4  requester 0 opcode.
- req0_a  input  DATA_W  requester 0 operand a.
- req0_b  input  DATA_W  requester 0 operand b.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as requester 0, for requester 1.
- alu_opcode  output  4  to ALU opcode.
- alu_a  output  DATA_W  to ALU a.
- alu_b  output  DATA_W  to ALU b.
- alu_x  input  DATA_W  from ALU x (low result).
- alu_y  input  DATA_W  from ALU y (high result).
- res_valid  output  1  result available.
- res_ready  input  1  result consumer accepts.
- res_data  output  2*DATA_W  masked result {y,x}.
- res_id  output  1  requester that issued the result.
- busy  output  1  high in any state other than IDLE.
- op_count  output  CNT_W  completed results, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clock edge), regardless of state:
  - state=IDLE, res_valid=0, res_data=0, res_id=0, busy=0, op_count=0.
  - alu_opcode/alu_a/alu_b=0, priority pointer = requester 0, both req*_ready=0.
  - An in-flight command or pending result is discarded.
- req*_ready is combinational: high only in IDLE, for the granted requester. A command transfers when valid&ready.
- FSM IDLE:
  - No valid: stay.
  - One valid: grant it.
  - Both valid: grant the pointer's requester, then the pointer flips to the other.
  - On grant: latch opcode/a/b into the ALU drive registers, latch res_id, go to ISSUE.
- FSM ISSUE (1 cycle): ALU inputs are stable from the registers. At the edge, capture the masked {alu_y,alu_x} into res_data, set res_valid=1, go to DONE.
- FSM DONE: hold res_valid, res_data and res_id stable until res_ready. On res_valid&res_ready: res_valid=0, op_count+1, go to IDLE.
- Latency and throughput:
  - Accept-to-res_valid is 2 cycles.
  - Minimum 3 cycles per operation (IDLE, ISSUE, DONE with res_ready high).
  - No new command is accepted until the result is consumed.
- ALU drive registers hold their values until the next grant; they are not cleared in IDLE.
- Result masking (the ALU leaves undefined bits stale, so the controller must zero them):
  - opcodes 0000,0001,0010,0110,0111,1000,1001 (1-bit results): res_data = {0..., alu_x[0]}.
  - opcodes 0011,0100,0101,1011,1111: res_data = {0 (DATA_W bits), alu_x}.
  - opcode 1010 (add): res_data = {0..., alu_y[0], alu_x}, i.e. carry at bit DATA_W.
  - opcodes 1100,1101,1110: res_data = {alu_y, alu_x}, full width.
- Priority pointer updates only on a contested grant (both valid). A single-requester grant leaves it unchanged.
- A requester may change or drop valid while not granted. Its command is sampled only in the accept cycle.
- op_count wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- Reset then req0 opcode=1010, a=9, b=8 -> req0_ready pulses 1 cycle; two cycles later res_valid=1, res_data=0x11, res_id=0; op_count=1 after the handshake.
- req0 and req1 both valid continuously, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1; one result every 3 cycles.
- req1 opcode=0110, a=5, b=3, with stale ALU upper bits forced to 1 -> res_data=0x01 exactly.
- req0 opcode=1100, a=0xF, b=0xF, res_ready held low 5 cycles -> res_data=0xE1 held stable with res_valid=1; no req*_ready pulses during the stall.
- rst_n low during DONE with res_valid=1 -> next cycle res_valid=0, busy=0, op_count=0; after release, contested req grants requester 0 first.
- 256 completions with CNT_W=8 -> op_count returns to 0.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one combinational opcode ALU between two
// requesters and returns the opcode-masked result over a valid/ready port.
module alu_rr_scheduler #(
   parameter int DATA_W = 4,
   parameter int CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0_valid,
   output logic                req0_ready,
   input  logic [3:0]          req0_opcode,
   input  logic [DATA_W-1:0]   req0_a,
   input  logic [DATA_W-1:0]   req0_b,
   input  logic                req1_valid,
   output logic                req1_ready,
   input  logic [3:0]          req1_opcode,
   input  logic [DATA_W-1:0]   req1_a,
   input  logic [DATA_W-1:0]   req1_b,
   output logic [3:0]          alu_opcode,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_x,
   input  logic [DATA_W-1:0]   alu_y,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [2*DATA_W-1:0] res_data,
   output logic                res_id,
   output logic                busy,
   output logic [CNT_W-1:0]    op_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t state;
   logic   ptr;
   logic   grant0;
   logic   grant1;
   logic   accept_en;

   // Ready stays low while reset is asserted so nothing transfers in that cycle.
   assign accept_en  = rst_n && (state == IDLE);
   assign grant0     = accept_en && req0_valid && (!req1_valid || !ptr);
   assign grant1     = accept_en && req1_valid && (!req0_valid || ptr);
   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state != IDLE);

   function automatic logic [2*DATA_W-1:0] mask_result(
      input logic [3:0]        op,
      input logic [DATA_W-1:0] x,
      input logic [DATA_W-1:0] y
   );
      logic [2*DATA_W-1:0] r;
      r = '0;
      case (op)
         4'b0011, 4'b0100, 4'b0101, 4'b1011, 4'b1111:
            r = {{DATA_W{1'b0}}, x};
         4'b1010:
            r = {{(DATA_W-1){1'b0}}, y[0], x};
         4'b1100, 4'b1101, 4'b1110:
            r = {y, x};
         default:
            r = {{(2*DATA_W-1){1'b0}}, x[0]};
      endcase
      return r;
   endfunction

   // NOTE: all state below is written with <= so every register samples the
   // pre-edge values; blocking here would let later statements see new values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         res_id     <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  alu_opcode <= grant1 ? req1_opcode : req0_opcode;
                  alu_a      <= grant1 ? req1_a      : req0_a;
                  alu_b      <= grant1 ? req1_b      : req0_b;
                  res_id     <= grant1;
                  if (req0_valid && req1_valid)
                     ptr <= ~ptr;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               res_data  <= mask_result(alu_opcode, alu_x, alu_y);
               res_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + CNT_W'(1);
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed self-checking bench for alu_rr_scheduler: masking vectors, stall,
// round-robin alternation, reset in DONE and counter wrap.
module tb_alu_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic       req0_ready, req1_ready;
   logic [3:0] req0_opcode, req1_opcode;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0] alu_opcode, alu_a, alu_b;
   logic [3:0] alu_x, alu_y;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_id, busy;
   logic [7:0] op_count;

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_rr_scheduler #(.DATA_W(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_x(alu_x), .alu_y(alu_y),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .busy(busy), .op_count(op_count)
   );

   typedef struct {
      bit         id;
      logic [3:0] op;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] exp;
      int         stall;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_req(input bit id, input bit v, input logic [3:0] op,
                            input logic [3:0] a, input logic [3:0] b);
      if (id) begin
         req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
      end
   endtask

   // Polls from a negedge for res_valid; leaves time at negedge+1.
   task automatic wait_res(input string name);
      int n = 0;
      while (!res_valid && n < 10) begin
         @(negedge clk); #1; n++;
      end
      check({name, "_res_valid_timeout"}, res_valid, 1'b1);
   endtask

   task automatic run_op(input vec_t v);
      @(negedge clk);
      res_ready = 1'b0;
      alu_x = v.x; alu_y = v.y;
      drive_req(v.id, 1'b1, v.op, v.a, v.b);
      #1;
      check("accept_ready", v.id ? req1_ready : req0_ready, 1'b1);
      check("accept_other", v.id ? req0_ready : req1_ready, 1'b0);
      @(negedge clk);
      drive_req(v.id, 1'b0, 4'h0, 4'h0, 4'h0);
      #1;
      check("issue_drive", {alu_opcode, alu_a, alu_b}, {v.op, v.a, v.b});
      check("issue_busy", {busy, res_valid}, 2'b10);
      @(negedge clk); #1;
      check("done_valid", res_valid, 1'b1);
      check("done_data", res_data, v.exp);
      check("done_id", res_id, v.id);
      for (int s = 0; s < v.stall; s++) begin
         drive_req(!v.id, 1'b1, 4'h3, 4'h1, 4'h2);
         @(negedge clk); #1;
         check("stall_hold", {res_valid, res_data, res_id}, {1'b1, v.exp, v.id});
         check("stall_no_ready", {req0_ready, req1_ready}, 2'b00);
      end
      drive_req(!v.id, 1'b0, 4'h0, 4'h0, 4'h0);
      res_ready = 1'b1;
      @(negedge clk); #1;
      res_ready = 1'b0;
      exp_cnt++;
      check("op_count", op_count, exp_cnt[7:0]);
      check("idle_after", {busy, res_valid}, 2'b00);
   endtask

   initial begin
      bit which;
      int last_g;
      int n;

      vecs[0] = '{1'b0, 4'b1010, 4'h9, 4'h8, 4'h1, 4'hF, 8'h11, 0};
      vecs[1] = '{1'b1, 4'b0110, 4'h5, 4'h3, 4'hF, 4'hF, 8'h01, 0};
      vecs[2] = '{1'b0, 4'b1100, 4'hF, 4'hF, 4'h1, 4'hE, 8'hE1, 5};
      vecs[3] = '{1'b1, 4'b0011, 4'h6, 4'h3, 4'h9, 4'hA, 8'h09, 0};
      vecs[4] = '{1'b0, 4'b0000, 4'h2, 4'h7, 4'hE, 4'hF, 8'h00, 1};
      vecs[5] = '{1'b1, 4'b1111, 4'hA, 4'h5, 4'h5, 4'hF, 8'h05, 0};
      vecs[6] = '{1'b0, 4'b1110, 4'hC, 4'h3, 4'h3, 4'hC, 8'hC3, 0};
      vecs[7] = '{1'b1, 4'b1010, 4'h3, 4'h4, 4'h7, 4'hE, 8'h07, 2};
      vecs[8] = '{1'b0, 4'b1001, 4'h1, 4'h1, 4'h3, 4'h8, 8'h01, 0};
      vecs[9] = '{1'b1, 4'b1011, 4'h4, 4'h2, 4'hA, 4'h1, 8'h0A, 0};

      rst_n = 1'b0; res_ready = 1'b0; alu_x = '0; alu_y = '0;
      drive_req(1'b0, 1'b1, 4'h1, 4'h1, 4'h1);
      drive_req(1'b1, 1'b1, 4'h2, 4'h2, 4'h2);
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", {req0_ready, req1_ready}, 2'b00);
      check("rst_state", {res_valid, busy, res_id}, 3'b000);
      check("rst_data", res_data, 8'h00);
      check("rst_count", op_count, 8'h00);
      check("rst_alu", {alu_opcode, alu_a, alu_b}, 12'h000);
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      drive_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i]);

      // Contested: both requesters always valid, consumer always ready.
      @(negedge clk);
      alu_x = 4'h3; alu_y = 4'h0; res_ready = 1'b1;
      drive_req(1'b0, 1'b1, 4'b1010, 4'h1, 4'h2);
      drive_req(1'b1, 1'b1, 4'b1010, 4'h2, 4'h1);
      last_g = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n = 0;
         while (!(req0_ready || req1_ready) && n < 10) begin
            @(negedge clk); #1; n++;
         end
         check("rr_grant_timeout", req0_ready | req1_ready, 1'b1);
         which = req1_ready;
         check("rr_grant_order", which, k[0]);
         if (k > 0) check("rr_period", cyc - last_g, 3);
         last_g = cyc;
         @(negedge clk); @(negedge clk); #1;
         check("rr_res", {res_valid, res_id, res_data}, {1'b1, k[0], 8'h03});
         if (k == 3) begin
            drive_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
            drive_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
         end
         @(negedge clk);
         exp_cnt++;
      end
      #1;
      check("rr_count", op_count, exp_cnt[7:0]);

      // Contested grant flips pointer to 1, then reset in DONE must restore it to 0.
      @(negedge clk);
      res_ready = 1'b0;
      drive_req(1'b0, 1'b1, 4'b1100, 4'h2, 4'h3);
      drive_req(1'b1, 1'b1, 4'b1100, 4'h3, 4'h2);
      #1;
      check("pre_rst_grant", {req0_ready, req1_ready}, 2'b10);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      drive_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      @(negedge clk); #1;
      check("pre_rst_done", res_valid, 1'b1);
      rst_n = 1'b0;
      @(negedge clk); #1;
      check("rst_done_clear", {res_valid, busy}, 2'b00);
      check("rst_done_count", op_count, 8'h00);
      exp_cnt = 0;
      drive_req(1'b0, 1'b1, 4'b0011, 4'h1, 4'h1);
      drive_req(1'b1, 1'b1, 4'b0011, 4'h2, 4'h2);
      rst_n = 1'b1;
      #1;
      check("post_rst_grant", {req0_ready, req1_ready}, 2'b10);
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      drive_req(1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      res_ready = 1'b1;
      #1;
      wait_res("post_rst");
      @(negedge clk); #1;
      check("post_rst_count", op_count, 8'h01);

      // Counter wrap: reset, then 256 back-to-back completions from requester 0.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive_req(1'b0, 1'b1, 4'b0000, 4'h0, 4'h0);
      #1;
      for (int i = 0; i < 256; i++) begin
         wait_res("wrap");
         @(negedge clk); #1;
         if (i == 254) check("wrap_255", op_count, 8'hFF);
      end
      check("wrap_0", op_count, 8'h00);
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
